// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: steps one instruction through EXEC/EXEC2/MEM/TRAP.
// Optional SEQ_PERF_CNT_EN adds mcycle/minstret counters.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_i,
    input  logic        jump_inst_i,
    input  logic        branch_inst_i,
    input  logic        ecall_inst_i,
    input  logic        ebreak_inst_i,
    input  logic        mret_inst_i,
    input  logic        illegal_inst_i,
    input  logic        lsu_r_en_i,
    input  logic        lsu_w_en_i,
    input  logic        rf_we_i,
    input  logic        branch_taken_i,
    input  logic        lsu_done_i,
    input  logic        lsu_err_i,
    output logic        cycle_counter_o,
    output logic        rf_we_o,
    output logic        lsu_req_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        trap_o,
    output logic        mepc_we_o,
    output logic [3:0]  mcause_o,
    output logic        mret_o,
`ifdef SEQ_PERF_CNT_EN
    output logic [63:0] minstret_o,
    output logic [63:0] mcycle_o,
`endif
    output logic        instr_ack_o
);

    localparam logic [1:0] PcInc  = 2'd0;
    localparam logic [1:0] PcAlu  = 2'd1;
    localparam logic [1:0] PcTvec = 2'd2;
    localparam logic [1:0] PcEpc  = 2'd3;

    localparam logic [3:0] CauseIllegal    = 4'd2;
    localparam logic [3:0] CauseBreak      = 4'd3;
    localparam logic [3:0] CauseLoadFault  = 4'd5;
    localparam logic [3:0] CauseStoreFault = 4'd7;
    localparam logic [3:0] CauseEcall      = 4'd11;

    typedef enum logic [2:0] {StIdle, StExec, StExec2, StMem, StTrap} state_e;

    state_e     state_q, state_d;
    logic [3:0] mcause_q, mcause_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcause_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            mcause_q <= mcause_d;
        end
    end

    assign mcause_o = mcause_q;

    always_comb begin
        state_d         = state_q;
        mcause_d        = mcause_q;
        cycle_counter_o = 1'b0;
        rf_we_o         = 1'b0;
        lsu_req_o       = 1'b0;
        pc_we_o         = 1'b0;
        pc_sel_o        = PcInc;
        trap_o          = 1'b0;
        mepc_we_o       = 1'b0;
        mret_o          = 1'b0;
        instr_ack_o     = 1'b0;

        case (state_q)
            StIdle: begin
                if (instr_valid_i) begin
                    state_d = StExec;
                end
            end

            StExec: begin
                if (illegal_inst_i) begin
                    state_d  = StTrap;
                    mcause_d = CauseIllegal;
                end else if (ecall_inst_i) begin
                    state_d  = StTrap;
                    mcause_d = CauseEcall;
                end else if (ebreak_inst_i) begin
                    state_d  = StTrap;
                    mcause_d = CauseBreak;
                end else if (mret_inst_i) begin
                    pc_we_o     = 1'b1;
                    pc_sel_o    = PcEpc;
                    mret_o      = 1'b1;
                    instr_ack_o = 1'b1;
                    state_d     = StIdle;
                end else if (lsu_r_en_i || lsu_w_en_i) begin
                    // lsu_done_i is not looked at here: a done in the request cycle is ignored.
                    lsu_req_o = 1'b1;
                    state_d   = StMem;
                end else if (jump_inst_i) begin
                    rf_we_o = rf_we_i;
                    state_d = StExec2;
                end else if (branch_inst_i) begin
                    if (branch_taken_i) begin
                        state_d = StExec2;
                    end else begin
                        pc_we_o     = 1'b1;
                        pc_sel_o    = PcInc;
                        instr_ack_o = 1'b1;
                        state_d     = StIdle;
                    end
                end else begin
                    rf_we_o     = rf_we_i;
                    pc_we_o     = 1'b1;
                    pc_sel_o    = PcInc;
                    instr_ack_o = 1'b1;
                    state_d     = StIdle;
                end
            end

            StExec2: begin
                cycle_counter_o = 1'b1;
                pc_we_o         = 1'b1;
                pc_sel_o        = PcAlu;
                instr_ack_o     = 1'b1;
                state_d         = StIdle;
            end

            StMem: begin
                if (lsu_done_i) begin
                    if (lsu_err_i) begin
                        state_d  = StTrap;
                        mcause_d = lsu_r_en_i ? CauseLoadFault : CauseStoreFault;
                    end else begin
                        rf_we_o     = lsu_r_en_i;
                        pc_we_o     = 1'b1;
                        pc_sel_o    = PcInc;
                        instr_ack_o = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end

            StTrap: begin
                trap_o      = 1'b1;
                mepc_we_o   = 1'b1;
                pc_we_o     = 1'b1;
                pc_sel_o    = PcTvec;
                instr_ack_o = 1'b1;
                state_d     = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic [63:0] mcycle_q, minstret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
            // Trap entry retires nothing.
            if (instr_ack_o && (state_q != StTrap)) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    assign mcycle_o   = mcycle_q;
    assign minstret_o = minstret_q;
`else
    // No performance counter state in this build.
`endif

    a_no_rf_we_with_trap: assert property (@(posedge clk) disable iff (!rst_n)
        !(rf_we_o && trap_o));

endmodule
